// File: rtl/uart_tx_serializer_if.sv
// Parallel-load / serial-out bundle for the UART transmitter.
// The master loads words; the slave serializes them onto TX_OUT.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, LSB-first data, optional parity, stop bit.
// Each serial bit is held for a captured Prescale number of CLK cycles.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input logic              CLK,
  input logic              RST,
  uart_tx_serializer_if.slave bus
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [5:0]            cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_q;
  logic [5:0]            presc_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  last_cyc;
  logic [DATA_WIDTH-1:0] data_sh;

  assign last_cyc   = (cnt == presc_q - 6'd1);
  assign data_sh    = data_q >> 1;
  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      presc_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt    <= '0;
          idx    <= '0;
          if (bus.Data_Valid) begin
            data_q   <= bus.P_DATA;
            par_en_q <= bus.PAR_EN;
            // parity is fixed at capture so later input changes cannot leak in
            par_q    <= (^bus.P_DATA) ^ bus.PAR_TYP;
            presc_q  <= (bus.Prescale == 6'd0) ? 6'd1 : bus.Prescale;
            state    <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (last_cyc) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            tx_q  <= data_q[0];
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DATA: begin
          if (last_cyc) begin
            cnt <= '0;
            if (idx == IW'(DATA_WIDTH - 1)) begin
              idx <= '0;
              if (par_en_q) begin
                state <= PARITY;
                tx_q  <= par_q;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              // shift so the next bit to send always sits at bit 0
              idx    <= idx + IW'(1);
              data_q <= data_sh;
              tx_q   <= data_sh[0];
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        PARITY: begin
          if (last_cyc) begin
            cnt   <= '0;
            state <= STOP;
            tx_q  <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        STOP: begin
          if (last_cyc) begin
            cnt    <= '0;
            state  <= IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          idx    <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame vector table plus
// back-to-back and mid-frame reset sequences.
module tb_uart_tx_serializer;
  logic CLK = 1'b0;
  logic RST;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 CLK = ~CLK;

  uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // bits[i] is the i-th bit on the line: start, data LSB first, [parity], stop
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [5:0]  presc;
    int          eff;
    int          nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_tx"}, bus.TX_OUT, 1'b1);
    chk({name, "_busy"}, bus.busy, 1'b0);
  endtask

  // Called at the negedge right after the start edge; checks every frame cycle.
  // mode 0: leave inputs alone; 1: poke Data_Valid and scramble inputs;
  // 2: change P_DATA to mid_data halfway through.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                             input int eff, input int mode, input logic [7:0] mid_data);
    int n;
    n = nbits * eff;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s_tx_c%0d", tag, c), bus.TX_OUT, bits[c / eff]);
      chk($sformatf("%s_busy_c%0d", tag, c), bus.busy, 1'b1);
      if (mode == 1) begin
        bus.Data_Valid = (c == n / 2) || (c == n - 1);
        bus.P_DATA     = 8'($urandom);
        bus.PAR_EN     = ~bus.PAR_EN;
        bus.PAR_TYP    = ~bus.PAR_TYP;
        bus.Prescale   = 6'($urandom_range(1, 63));
      end else if (mode == 2 && c == n / 2) begin
        bus.P_DATA = mid_data;
      end
      @(negedge CLK);
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = p;
    bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd1,  1,  10, 12'b0011_0100_1010};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 6'd1,  1,  11, 12'b0110_0000_1110};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 6'd1,  1,  11, 12'b0100_0000_1110};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 6'd16, 16, 10, 12'b0010_0000_0000};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 6'd0,  1,  11, 12'b0110_1011_0100};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 6'd3,  3,  11, 12'b0101_1000_0110};

    bus.P_DATA = 8'h00; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0; bus.Prescale = 6'd1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk_idle("reset");
    RST = 1'b0;
    @(negedge CLK);
    chk_idle("post_reset");

    foreach (vecs[i]) begin
      launch(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].presc);
      check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, vecs[i].eff, 1, 8'h00);
      chk_idle($sformatf("vec%0d_end", i));
      bus.Data_Valid = 1'b0;
      @(negedge CLK);
      chk_idle($sformatf("vec%0d_noqueue", i));
    end

    // Data_Valid held high: 0x3C then 0xFF with exactly one idle cycle between
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Prescale = 6'd1;
    bus.Data_Valid = 1'b1;
    @(negedge CLK);
    check_frame("b2b_a", 12'b0010_0111_1000, 10, 1, 2, 8'hFF);
    chk_idle("b2b_gap");
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    check_frame("b2b_b", 12'b0011_1111_1110, 10, 1, 0, 8'h00);
    chk_idle("b2b_end");
    @(negedge CLK);

    // Reset during DATA bit 3 with Data_Valid also high: reset wins
    launch(8'hF0, 1'b0, 1'b0, 6'd4);
    for (int c = 0; c < 17; c++) @(negedge CLK);
    chk("rst_mid_tx_bit3", bus.TX_OUT, 1'b0);
    RST = 1'b1;
    bus.Data_Valid = 1'b1;
    @(negedge CLK);
    chk_idle("rst_abort");
    RST = 1'b0;
    bus.Data_Valid = 1'b0;
    @(negedge CLK);
    chk_idle("rst_no_resume");
    launch(8'h81, 1'b0, 1'b0, 6'd4);
    check_frame("after_rst", 12'b0011_0000_0010, 10, 4, 0, 8'h00);
    chk_idle("after_rst_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
